// File: rtl/differentiator.sv
// differentiator: streaming y[n] = x[n] - x[n-DELAY] mod 2^WIDTH with valid/ready on both sides
module differentiator #(
  parameter int WIDTH = 10,
  parameter int DELAY = 1
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] input_0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] output_0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             primed
);
  localparam int PW = DELAY > 1 ? $clog2(DELAY) : 1;
  localparam int FW = $clog2(DELAY + 1);
  typedef enum logic [1:0] {EMPTY, FILLING, PRIMED} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] hist [DELAY];
  logic [PW-1:0] ptr;
  logic [FW-1:0] fill;
  logic accept;
  assign in_ready = !system1000_rst && !clear && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign primed = state == PRIMED;
  always_comb begin
    state_next = state;
    if (clear) state_next = EMPTY;
    else if (accept && state != PRIMED) state_next = fill == FW'(DELAY - 1) ? PRIMED : FILLING;
  end
  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) state <= EMPTY;
    else state <= state_next;
  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) begin
      output_0 <= '0;
      out_valid <= 1'b0;
      ptr <= '0;
      fill <= '0;
      for (int i = 0; i < DELAY; i++) hist[i] <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      ptr <= '0;
      fill <= '0;
      for (int i = 0; i < DELAY; i++) hist[i] <= '0;
    end else if (accept) begin
      output_0 <= input_0 - hist[ptr];
      hist[ptr] <= input_0;
      ptr <= ptr == PW'(DELAY - 1) ? '0 : ptr + 1'b1;
      fill <= primed ? fill : fill + 1'b1;
      out_valid <= 1'b1;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_differentiator.sv
// tb_differentiator: vector tables, corner sequences and randomized model checks for DELAY=1 and DELAY=4
module tb_differentiator;
  typedef struct {bit clr; int x; int y; bit p;} vec_t;
  logic clk = 0, rst = 0;
  logic c1 = 0, iv1 = 0, or1 = 1, ir1, ov1, p1;
  logic c4 = 0, iv4 = 0, or4 = 1, ir4, ov4, p4;
  logic [9:0] x1 = '0, y1, x4 = '0, y4;
  int checks = 0, errors = 0;
  vec_t t1 [9];
  vec_t t4 [8];
  differentiator #(.WIDTH(10), .DELAY(1)) d1 (.system1000(clk), .system1000_rst(rst), .clear(c1),
    .input_0(x1), .in_valid(iv1), .in_ready(ir1), .output_0(y1), .out_valid(ov1), .out_ready(or1), .primed(p1));
  differentiator #(.WIDTH(10), .DELAY(4)) d4 (.system1000(clk), .system1000_rst(rst), .clear(c4),
    .input_0(x4), .in_valid(iv4), .in_ready(ir4), .output_0(y4), .out_valid(ov4), .out_ready(or4), .primed(p4));
  always #5 clk = ~clk;
  function automatic int wrap(input int v);
    logic [9:0] t;
    t = v[9:0];
    return int'($signed(t));
  endfunction
  function automatic int sv(input logic [9:0] v);
    return int'($signed(v));
  endfunction
  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask
  task automatic step1(input int x);
    x1 = x[9:0]; iv1 = 1; or1 = 1;
    @(posedge clk); #1;
    iv1 = 0;
  endtask
  task automatic step4(input int x);
    x4 = x[9:0]; iv4 = 1; or4 = 1;
    @(posedge clk); #1;
    iv4 = 0;
  endtask
  task automatic clr1;
    c1 = 1; iv1 = 0; #1;
    chk("d1_clear_in_ready", int'(ir1), 0);
    @(posedge clk); #1;
    chk("d1_clear_out_valid", int'(ov1), 0);
    chk("d1_clear_primed", int'(p1), 0);
    c1 = 0;
  endtask
  task automatic clr4;
    c4 = 1; iv4 = 0; #1;
    chk("d4_clear_in_ready", int'(ir4), 0);
    @(posedge clk); #1;
    chk("d4_clear_out_valid", int'(ov4), 0);
    chk("d4_clear_primed", int'(p4), 0);
    c4 = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    int s, xp, n, cyc, x, r, mo;
    bit mv, acc;
    int hq[$];
    t1 = '{'{0, 5, 5, 1}, '{0, 7, 2, 1}, '{0, -3, -10, 1}, '{0, -3, 0, 1},
           '{1, -512, -512, 1}, '{0, 511, -1, 1}, '{1, 0, 0, 1}, '{0, -512, -512, 1}, '{0, 1, -511, 1}};
    for (int i = 0; i < 8; i++) t4[i] = '{0, i + 1, i < 4 ? i + 1 : 4, i >= 3};
    #2 rst = 1; #1;
    chk("rst_out_valid1", int'(ov1), 0);
    chk("rst_output1", sv(y1), 0);
    chk("rst_primed1", int'(p1), 0);
    chk("rst_in_ready1", int'(ir1), 0);
    chk("rst_out_valid4", int'(ov4), 0);
    chk("rst_primed4", int'(p4), 0);
    @(negedge clk); @(negedge clk);
    rst = 0; #1;
    chk("post_rst_in_ready1", int'(ir1), 1);
    chk("post_rst_in_ready4", int'(ir4), 1);
    for (int i = 0; i < 9; i++) begin
      if (t1[i].clr) clr1;
      step1(t1[i].x);
      chk("d1_vec_y", sv(y1), t1[i].y);
      chk("d1_vec_valid", int'(ov1), 1);
      chk("d1_vec_primed", int'(p1), int'(t1[i].p));
    end
    for (int i = 0; i < 8; i++) begin
      step4(t4[i].x);
      chk("d4_vec_y", sv(y4), t4[i].y);
      chk("d4_vec_primed", int'(p4), int'(t4[i].p));
    end
    clr1;
    step1(10);
    chk("bp_first", sv(y1), 10);
    x1 = 10'd20; iv1 = 1; or1 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", int'(ir1), 0);
      @(posedge clk); #1;
      chk("bp_hold_y", sv(y1), 10);
      chk("bp_hold_valid", int'(ov1), 1);
    end
    or1 = 1;
    @(posedge clk); #1;
    chk("bp_resume1", sv(y1), 10);
    x1 = 10'd25;
    @(posedge clk); #1;
    chk("bp_resume2", sv(y1), 5);
    iv1 = 0;
    @(posedge clk); #1;
    chk("bp_drain_valid", int'(ov1), 0);
    chk("bp_drain_keep", sv(y1), 5);
    clr4;
    step4(1); step4(2);
    chk("half_valid", int'(ov4), 1);
    chk("half_primed", int'(p4), 0);
    or4 = 0;
    clr4;
    or4 = 1;
    for (int i = 0; i < 5; i++) begin
      step4(9 + i);
      chk("post_clear_y", sv(y4), i < 4 ? 9 + i : 4);
    end
    clr1;
    s = 0; n = 0; cyc = 0; mv = 0; mo = 0;
    xp = int'($urandom_range(0, 1023)) - 512;
    while (n < 1000 && cyc < 5000) begin
      cyc++;
      iv1 = $urandom_range(0, 3) != 0;
      or1 = $urandom_range(0, 3) != 0;
      x1 = 10'(wrap(s + xp));
      #1;
      chk("int_in_ready", int'(ir1), int'(!mv || or1));
      acc = iv1 && (!mv || or1);
      @(posedge clk); #1;
      if (acc) begin
        mo = xp; mv = 1; n++;
        s = wrap(s + xp);
        xp = int'($urandom_range(0, 1023)) - 512;
      end else if (or1) mv = 0;
      chk("int_out_valid", int'(ov1), int'(mv));
      if (mv) chk("int_y", sv(y1), mo);
    end
    chk("int_count", n, 1000);
    iv1 = 0; or1 = 1;
    clr4;
    mv = 0;
    for (int k = 0; k < 600; k++) begin
      x = int'($urandom_range(0, 1023)) - 512;
      x4 = x[9:0];
      iv4 = $urandom_range(0, 2) != 0;
      or4 = $urandom_range(0, 2) != 0;
      #1;
      chk("rnd_in_ready", int'(ir4), int'(!mv || or4));
      acc = iv4 && (!mv || or4);
      @(posedge clk); #1;
      if (acc) begin
        r = hq.size() >= 4 ? hq[hq.size() - 4] : 0;
        mo = wrap(x - r); mv = 1;
        hq.push_back(x);
      end else if (or4) mv = 0;
      chk("rnd_out_valid", int'(ov4), int'(mv));
      if (mv) chk("rnd_y", sv(y4), mo);
      chk("rnd_primed", int'(p4), int'(hq.size() >= 4));
    end
    clr4;
    step4(77);
    step1(33);
    chk("pre_rst_y4", sv(y4), 77);
    #2 rst = 1; #1;
    chk("async_rst_y4", sv(y4), 0);
    chk("async_rst_valid4", int'(ov4), 0);
    chk("async_rst_primed4", int'(p4), 0);
    chk("async_rst_y1", sv(y1), 0);
    chk("async_rst_ready4", int'(ir4), 0);
    @(negedge clk);
    rst = 0;
    step4(6);
    chk("after_rst_y4", sv(y4), 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/differentiator.md
Name: differentiator

Overview:
- Streaming first-difference block: y[n] = x[n] - x[n-DELAY], computed modulo 2^WIDTH.
- Exact inverse of the team's wrapping integrator. Integrator followed by differentiator (DELAY=1), both starting from reset, returns the original sample stream bit-exactly.
- Sits between a sample source and the downstream integrator/DSP chain. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 10, sample width in bits, signed two's complement.
- DELAY, 1, differential delay M in samples, range 1..64.

Ports:
- system1000, input, 1, clock; all state updates on the rising edge.
- system1000_rst, input, 1, reset, asynchronous and active-high.
- clear, input, 1, synchronous flush of the history and pipeline.
- input_0, input, WIDTH, signed input sample x[n].
- in_valid, input, 1, input_0 holds a sample.
- in_ready, output, 1, block can accept a sample this cycle.
- output_0, output, WIDTH, signed difference y[n].
- out_valid, output, 1, output_0 holds a result.
- out_ready, input, 1, downstream accepts output_0 this cycle.
- primed, output, 1, DELAY samples accepted since reset or clear, so history holds real data.

Behaviour:
- Reset (async, system1000_rst=1):
  - out_valid=0, output_0=0, primed=0.
  - All DELAY history entries=0, write pointer=0, fill counter=0.
  - in_ready=0 while reset is asserted, then follows the rule below from the first clock after deassertion.
- Handshake:
  - in_ready = !clear && (!out_valid || out_ready).
  - Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
- History:
  - Circular buffer of DELAY entries with write pointer ptr (0..DELAY-1).
  - On accept: output_0 <= input_0 - hist[ptr], wrapped to WIDTH bits with no saturation. Then hist[ptr] <= input_0; ptr <= (ptr==DELAY-1) ? 0 : ptr+1.
  - Pre-prime history entries read as 0, so the first DELAY outputs equal the inputs.
- Latency and throughput:
  - Exactly 1 cycle: a sample accepted at edge k gives out_valid=1 and output_0 valid after edge k.
  - Full throughput of one sample per cycle when out_ready=1.
- Output register:
  - On accept: out_valid <= 1.
  - On output transfer without accept: out_valid <= 0.
  - Transfer and accept in the same cycle: out_valid stays 1 and output_0 takes the new value.
  - output_0 and out_valid hold stable while out_valid && !out_ready.
  - output_0 keeps its last value when out_valid=0.
- Fill counter and primed:
  - Fill counter saturates at DELAY.
  - primed=1 once DELAY samples have been accepted; it stays 1 until reset or clear.
- States: EMPTY (fill=0), FILLING (0<fill<DELAY), PRIMED (fill=DELAY).
  - EMPTY -> FILLING on accept.
  - FILLING -> PRIMED on the DELAY-th accept. When DELAY=1, EMPTY -> PRIMED directly.
  - clear or reset returns any state to EMPTY.
- clear:
  - Takes precedence over everything. in_ready=0 during clear, so no sample is accepted.
  - Next edge: history=0, ptr=0, fill=0, primed=0, out_valid=0. Any pending output is discarded.
- Arithmetic wrap example (WIDTH=10): 511 - (-512) = 1023, which wraps to -1. -512 - 1 wraps to 511.
- Reset mid-stream: any held output and all history are lost immediately; there is no partial-state recovery.

Test Plan:
- DELAY=1, out_ready=1, inputs 5, 7, -3, -3 -> outputs 5, 2, -10, 0, each one cycle after accept; primed=1 after the first accept.
- DELAY=1, inputs -512 then 511 -> outputs -512 then -1. Inputs 0 then -512 then 1 -> 0, -512, 513 wrapped to -511.
- Integrator(WIDTH=10) output fed into differentiator (DELAY=1): random 1000-sample stream -> output_0 equals the original stream bit-exactly.
- DELAY=4, inputs 1..8 continuous -> outputs 1, 2, 3, 4, 4, 4, 4, 4; primed rises after the 4th accept.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, output_0 stable, no sample lost. When out_ready returns to 1, the stream continues with correct differences.
- clear asserted while out_valid=1 and DELAY=4 is half-filled -> out_valid=0 and primed=0 next cycle. A following input 9 -> output 9. Async reset pulse mid-stream -> outputs drop to 0 without a clock edge.
